// File: rtl/dmc_pkg.sv
// Shared definitions for the data-memory bus controller and the memory stage.
package dmc_pkg;

   // Load type codes, shared with the memory-stage access decode.
   localparam logic [2:0] LT_LB   = 3'b000;
   localparam logic [2:0] LT_LH   = 3'b001;
   localparam logic [2:0] LT_LW   = 3'b010;
   localparam logic [2:0] LT_LBU  = 3'b100;
   localparam logic [2:0] LT_LHU  = 3'b101;
   localparam logic [2:0] LT_NONE = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDone
   } dmc_state_e;

   // A load is misaligned when a half crosses a half boundary or a word is not word aligned.
   function automatic logic load_misaligned(input logic [2:0] lt, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if ((lt == LT_LH) || (lt == LT_LHU)) begin
         mis = off[0];
      end else if (lt == LT_LW) begin
         mis = (off != 2'b00);
      end
      return mis;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Lane select plus sign/zero extension of a read word into a load result.
module load_formatter
   import dmc_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  load_type,
   output logic [31:0] result
);

   logic [31:0] shifted;

   // Move the addressed byte/half down to bit 0, then extend per load type.
   always_comb begin
      shifted = word >> {off, 3'b000};
      unique case (load_type)
         LT_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
         LT_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
         LT_LW:   result = shifted;
         LT_LBU:  result = {24'h000000, shifted[7:0]};
         LT_LHU:  result = {16'h0000, shifted[15:0]};
         default: result = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory bus controller: one load/store per request, valid/ready request
// plus single-cycle response, timeout abort, formatted load result.
module data_mem_ctrl
   import dmc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_enable,
   input  logic        read_enable,
   input  logic [31:0] mem_addr,
   input  logic [31:0] wr_data,
   input  logic [3:0]  write_byte_enable,
   input  logic [2:0]  load_type,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rdata,
   input  logic        bus_rsp_err,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        store_done,
   output logic        access_fault,
   output logic        misaligned
);

   localparam logic [16:0] TimeoutLimit = 17'(TIMEOUT_CYCLES);

   dmc_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  off_q, off_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [2:0]  lt_q, lt_d;
   logic [15:0] cnt_q, cnt_d;
   logic        req_valid_q, req_valid_d;
   logic        load_valid_q, load_valid_d;
   logic        store_done_q, store_done_d;
   logic        fault_q, fault_d;
   logic        mis_q, mis_d;
   logic [31:0] load_data_q, load_data_d;

   logic        req;
   logic        req_mis;
   logic        tout;
   logic [31:0] fmt_data;

   load_formatter u_load_formatter (
      .word      (bus_rdata),
      .off       (off_q),
      .load_type (lt_q),
      .result    (fmt_data)
   );

   assign req     = wr_enable | read_enable;
   assign req_mis = wr_enable ? (write_byte_enable == 4'b0000)
                              : load_misaligned(load_type, mem_addr[1:0]);
   // Fires in the cycle whose increment would bring the counter up to the limit.
   assign tout    = (({1'b0, cnt_q} + 17'd1) >= TimeoutLimit);

   // Next-state and registered-output computation for the access FSM.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      off_d        = off_q;
      wstrb_d      = wstrb_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      lt_d         = lt_q;
      cnt_d        = cnt_q;
      req_valid_d  = req_valid_q;
      load_valid_d = 1'b0;
      store_done_d = 1'b0;
      fault_d      = 1'b0;
      mis_d        = 1'b0;
      load_data_d  = 32'h0000_0000;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               addr_d  = {mem_addr[31:2], 2'b00};
               off_d   = mem_addr[1:0];
               wstrb_d = write_byte_enable << mem_addr[1:0];
               wdata_d = wr_data << {mem_addr[1:0], 3'b000};
               we_d    = wr_enable;
               lt_d    = load_type;
               if (req_mis) begin
                  state_d      = StDone;
                  mis_d        = 1'b1;
                  load_valid_d = ~wr_enable;
                  store_done_d = wr_enable;
               end else begin
                  state_d     = StReq;
                  req_valid_d = 1'b1;
                  cnt_d       = 16'd0;
               end
            end
         end
         StReq: begin
            if (cnt_q != 16'hFFFF) begin
               cnt_d = cnt_q + 16'd1;
            end
            // An accepted request wins over a coincident timeout so the bus is never left orphaned.
            if (bus_req_ready) begin
               state_d     = StWait;
               req_valid_d = 1'b0;
            end else if (tout) begin
               state_d      = StDone;
               req_valid_d  = 1'b0;
               fault_d      = 1'b1;
               load_valid_d = ~we_q;
               store_done_d = we_q;
            end
         end
         StWait: begin
            if (cnt_q != 16'hFFFF) begin
               cnt_d = cnt_q + 16'd1;
            end
            if (bus_rsp_valid) begin
               state_d      = StDone;
               fault_d      = bus_rsp_err;
               load_valid_d = ~we_q;
               store_done_d = we_q;
               if (!we_q && !bus_rsp_err) begin
                  load_data_d = fmt_data;
               end
            end else if (tout) begin
               state_d      = StDone;
               fault_d      = 1'b1;
               load_valid_d = ~we_q;
               store_done_d = we_q;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         addr_q       <= 32'h0000_0000;
         off_q        <= 2'b00;
         wstrb_q      <= 4'b0000;
         wdata_q      <= 32'h0000_0000;
         we_q         <= 1'b0;
         lt_q         <= LT_NONE;
         cnt_q        <= 16'd0;
         req_valid_q  <= 1'b0;
         load_valid_q <= 1'b0;
         store_done_q <= 1'b0;
         fault_q      <= 1'b0;
         mis_q        <= 1'b0;
         load_data_q  <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         off_q        <= off_d;
         wstrb_q      <= wstrb_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         lt_q         <= lt_d;
         cnt_q        <= cnt_d;
         req_valid_q  <= req_valid_d;
         load_valid_q <= load_valid_d;
         store_done_q <= store_done_d;
         fault_q      <= fault_d;
         mis_q        <= mis_d;
         load_data_q  <= load_data_d;
      end
   end

   assign stall = ((state_q == StIdle) && req) || (state_q == StReq) || (state_q == StWait);

   assign bus_req_valid = req_valid_q;
   assign bus_addr      = addr_q;
   assign bus_we        = we_q;
   assign bus_wstrb     = wstrb_q;
   assign bus_wdata     = wdata_q;
   assign load_data     = load_data_q;
   assign load_valid    = load_valid_q;
   assign store_done    = store_done_q;
   assign access_fault  = fault_q;
   assign misaligned    = mis_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: bus responder model plus completion scoreboard.
module tb_data_mem_ctrl;
   import dmc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_enable = 1'b0;
   logic        read_enable = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  write_byte_enable = '0;
   logic [2:0]  load_type = LT_NONE;
   logic        bus_req_valid;
   logic        bus_req_ready = 1'b0;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_rsp_valid = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        bus_rsp_err = 1'b0;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        store_done;
   logic        access_fault;
   logic        misaligned;

   // Expected completion: {load_valid, store_done, access_fault, misaligned, load_data}
   typedef logic [35:0] exp_t;
   exp_t exp_q[$];

   int tests_run = 0;
   int fails = 0;

   // Bus model configuration
   bit          cfg_ready_en = 1'b1;
   int          cfg_rsp_delay = 0;
   logic [31:0] cfg_rdata = '0;
   logic        cfg_err = 1'b0;
   int          rsp_cnt = -1;

   data_mem_ctrl #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .wr_enable         (wr_enable),
      .read_enable       (read_enable),
      .mem_addr          (mem_addr),
      .wr_data           (wr_data),
      .write_byte_enable (write_byte_enable),
      .load_type         (load_type),
      .bus_req_valid     (bus_req_valid),
      .bus_req_ready     (bus_req_ready),
      .bus_addr          (bus_addr),
      .bus_we            (bus_we),
      .bus_wstrb         (bus_wstrb),
      .bus_wdata         (bus_wdata),
      .bus_rsp_valid     (bus_rsp_valid),
      .bus_rdata         (bus_rdata),
      .bus_rsp_err       (bus_rsp_err),
      .stall             (stall),
      .load_data         (load_data),
      .load_valid        (load_valid),
      .store_done        (store_done),
      .access_fault      (access_fault),
      .misaligned        (misaligned)
   );

   always #5 clk = ~clk;

   // Bus responder: ready one cycle after valid, response cfg_rsp_delay cycles after handshake.
   always @(negedge clk) begin
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      if (rst) begin
         bus_req_ready = 1'b0;
      end else if (bus_req_ready) begin
         bus_req_ready = 1'b0;
         rsp_cnt       = cfg_rsp_delay;
      end else if (bus_req_valid && cfg_ready_en) begin
         bus_req_ready = 1'b1;
      end
      if (rsp_cnt == 0) begin
         bus_rsp_valid = 1'b1;
         bus_rdata     = cfg_rdata;
         bus_rsp_err   = cfg_err;
      end
      if (rsp_cnt >= 0) rsp_cnt = rsp_cnt - 1;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic [2:0] lt);
      wr_enable         = we;
      read_enable       = ~we;
      mem_addr          = a;
      wr_data           = wd;
      write_byte_enable = be;
      load_type         = lt;
   endtask

   task automatic end_req;
      wr_enable   = 1'b0;
      read_enable = 1'b0;
   endtask

   // Waits (bounded) for a completion pulse; cyc counts edges taken.
   task automatic wait_done(input int budget, output bit seen, output int cyc);
      seen = 1'b0;
      cyc  = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         cyc++;
         if (load_valid || store_done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) step();
      tests_run++;
      if ({bus_req_valid, bus_we, stall, load_valid, store_done, access_fault, misaligned}
          !== 7'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b required 0000000",
                  {bus_req_valid, bus_we, stall, load_valid, store_done, access_fault, misaligned});
      end
      tests_run++;
      if ({bus_addr, bus_wdata, bus_wstrb, load_data} !== 100'b0) begin
         fails++;
         $display("FAIL reset_data: addr %h wdata %h wstrb %b ldata %h required all 0",
                  bus_addr, bus_wdata, bus_wstrb, load_data);
      end
      rst = 1'b0;
      step();
   endtask

   // LW with minimum latency; checks stall and pulse cycle by cycle.
   task automatic test_lw;
      logic [3:0] stall_seen;
      exp_t       got;
      exp_t       e;
      cfg_rdata = 32'hDEADBEEF;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
      start_req(1'b0, 32'h0000_1000, 32'h0, 4'b0000, LT_LW);
      #1;
      stall_seen[0] = stall;
      step();
      end_req();
      tests_run++;
      if ({bus_req_valid, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h0000_1000}) begin
         fails++;
         $display("FAIL lw_req: got v=%b we=%b addr=%h required v=1 we=0 addr=00001000",
                  bus_req_valid, bus_we, bus_addr);
      end
      stall_seen[1] = stall;
      step();
      stall_seen[2] = stall;
      step();
      stall_seen[3] = stall;
      tests_run++;
      if (stall_seen !== 4'b0111) begin
         fails++;
         $display("FAIL lw_stall: got %b required 0111 (cycle3..0)", stall_seen);
      end
      got = {load_valid, store_done, access_fault, misaligned, load_data};
      e   = exp_q.pop_front();
      tests_run++;
      if (got !== e) begin
         fails++;
         $display("FAIL lw_done_cycle3: got %h required %h", got, e);
      end
      step();
      tests_run++;
      if ({load_valid, store_done, stall} !== 3'b000) begin
         fails++;
         $display("FAIL lw_pulse_width: got %b required 000", {load_valid, store_done, stall});
      end
   endtask

   // Table of loads exercising lane select and extension.
   task automatic test_load_format;
      logic [31:0] t_addr[8]  = '{32'h1003, 32'h1003, 32'h4002, 32'h4002,
                                  32'h4000, 32'h5001, 32'h6000, 32'h7004};
      logic [2:0]  t_lt[8]    = '{LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LH, LT_LB, LT_NONE, LT_LW};
      logic [31:0] t_rd[8]    = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h80011234,
                                  32'h80011234, 32'h00007F00, 32'hFFFFFFFF, 32'h12345678};
      logic [31:0] t_exp[8]   = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                  32'h00001234, 32'h0000007F, 32'h00000000, 32'h12345678};
      bit   seen;
      int   cyc;
      exp_t got;
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         cfg_rdata = t_rd[i];
         exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, t_exp[i]});
         start_req(1'b0, t_addr[i], 32'h0, 4'b0000, t_lt[i]);
         step();
         end_req();
         wait_done(10, seen, cyc);
         got = {load_valid, store_done, access_fault, misaligned, load_data};
         e   = exp_q.pop_front();
         tests_run++;
         if (!seen || cyc != 2 || got !== e) begin
            fails++;
            $display("FAIL load_fmt[%0d]: got %h seen=%0d cyc=%0d required %h cyc=2",
                     i, got, seen, cyc, e);
         end
         step();
      end
   endtask

   // Stores: check lane alignment on the bus and the completion pulse.
   task automatic test_store;
      logic [31:0] t_addr[4]  = '{32'h2002, 32'h2002, 32'h2000, 32'h2001};
      logic [31:0] t_wd[4]    = '{32'h000000AB, 32'h0000BEEF, 32'h11223344, 32'h0000005A};
      logic [3:0]  t_be[4]    = '{4'b0001, 4'b0011, 4'b1111, 4'b0001};
      logic [3:0]  t_strb[4]  = '{4'b0100, 4'b1100, 4'b1111, 4'b0010};
      logic [31:0] t_wdat[4]  = '{32'h00AB0000, 32'hBEEF0000, 32'h11223344, 32'h00005A00};
      bit   seen;
      int   cyc;
      exp_t got;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
         start_req(1'b1, t_addr[i], t_wd[i], t_be[i], LT_NONE);
         step();
         end_req();
         tests_run++;
         if ({bus_req_valid, bus_we, bus_addr, bus_wstrb, bus_wdata} !==
             {1'b1, 1'b1, t_addr[i] & 32'hFFFFFFFC, t_strb[i], t_wdat[i]}) begin
            fails++;
            $display("FAIL store_bus[%0d]: got v=%b we=%b a=%h s=%b d=%h required s=%b d=%h",
                     i, bus_req_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
                     t_strb[i], t_wdat[i]);
         end
         wait_done(10, seen, cyc);
         got = {load_valid, store_done, access_fault, misaligned, load_data};
         e   = exp_q.pop_front();
         tests_run++;
         if (!seen || cyc != 2 || got !== e) begin
            fails++;
            $display("FAIL store_done[%0d]: got %h seen=%0d cyc=%0d required %h cyc=2",
                     i, got, seen, cyc, e);
         end
         step();
      end
   endtask

   // Misaligned loads and empty-mask store: DONE next cycle, no bus request.
   task automatic test_misaligned;
      logic        t_we[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] t_addr[4] = '{32'h3001, 32'h3002, 32'h3003, 32'h3000};
      logic [2:0]  t_lt[4]   = '{LT_LH, LT_LW, LT_LHU, LT_NONE};
      exp_t got;
      exp_t e;
      logic st0;
      cfg_rdata = 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({~t_we[i], t_we[i], 1'b0, 1'b1, 32'h0});
         start_req(t_we[i], t_addr[i], 32'hFFFFFFFF, 4'b0000, t_lt[i]);
         #1;
         st0 = stall;
         step();
         end_req();
         got = {load_valid, store_done, access_fault, misaligned, load_data};
         e   = exp_q.pop_front();
         tests_run++;
         if (got !== e || bus_req_valid !== 1'b0 || st0 !== 1'b1 || stall !== 1'b0) begin
            fails++;
            $display("FAIL misaligned[%0d]: got %h reqv=%b stall0=%b stall1=%b required %h 0 1 0",
                     i, got, bus_req_valid, st0, stall, e);
         end
         step();
      end
   endtask

   // Ready held low: request valid for exactly TIMEOUT_CYCLES cycles, then fault.
   task automatic test_timeout;
      int   vcount;
      bit   seen;
      exp_t got;
      exp_t e;
      cfg_ready_en = 1'b0;
      cfg_rdata    = 32'h12345678;
      vcount       = 0;
      seen         = 1'b0;
      exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
      start_req(1'b0, 32'h0000_8000, 32'h0, 4'b0000, LT_LW);
      step();
      end_req();
      for (int i = 0; i < 20; i++) begin
         if (bus_req_valid) vcount++;
         if (load_valid || store_done) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      got = {load_valid, store_done, access_fault, misaligned, load_data};
      e   = exp_q.pop_front();
      tests_run++;
      if (vcount != 4) begin
         fails++;
         $display("FAIL timeout_valid_cycles: got %0d required 4", vcount);
      end
      tests_run++;
      if (!seen || got !== e) begin
         fails++;
         $display("FAIL timeout_fault: got %h seen=%0d required %h", got, seen, e);
      end
      cfg_ready_en = 1'b1;
      step();
   endtask

   task automatic test_rsp_err;
      bit   seen;
      int   cyc;
      exp_t got;
      exp_t e;
      cfg_err   = 1'b1;
      cfg_rdata = 32'hCAFEF00D;
      exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
      start_req(1'b0, 32'h0000_9000, 32'h0, 4'b0000, LT_LW);
      step();
      end_req();
      wait_done(10, seen, cyc);
      got = {load_valid, store_done, access_fault, misaligned, load_data};
      e   = exp_q.pop_front();
      tests_run++;
      if (!seen || got !== e) begin
         fails++;
         $display("FAIL rsp_err: got %h seen=%0d required %h", got, seen, e);
      end
      cfg_err = 1'b0;
      step();
   endtask

   // Reset during WAIT with a late response: controller must stay idle.
   task automatic test_reset_mid;
      int spurious;
      cfg_rsp_delay = 3;
      cfg_rdata     = 32'h55555555;
      spurious      = 0;
      start_req(1'b0, 32'h0000_A000, 32'h0, 4'b0000, LT_LW);
      step();
      end_req();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if ({stall, bus_req_valid, load_valid} !== 3'b000) begin
         fails++;
         $display("FAIL reset_mid_idle: got stall/v/lv=%b required 000",
                  {stall, bus_req_valid, load_valid});
      end
      for (int i = 0; i < 6; i++) begin
         step();
         if (load_valid || store_done || stall || bus_req_valid) spurious++;
      end
      tests_run++;
      if (spurious != 0) begin
         fails++;
         $display("FAIL reset_mid_late_rsp: got %0d active cycles required 0", spurious);
      end
      cfg_rsp_delay = 0;
   endtask

   // Second access issued in the cycle after DONE completes with normal latency.
   task automatic test_back_to_back;
      bit   seen;
      int   cyc;
      exp_t got;
      exp_t e;
      cfg_rdata = 32'h0BADF00D;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 32'h0BADF00D});
      exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
      start_req(1'b0, 32'h0000_B000, 32'h0, 4'b0000, LT_LW);
      step();
      end_req();
      wait_done(10, seen, cyc);
      got = {load_valid, store_done, access_fault, misaligned, load_data};
      e   = exp_q.pop_front();
      tests_run++;
      if (!seen || cyc != 2 || got !== e) begin
         fails++;
         $display("FAIL b2b_first: got %h seen=%0d cyc=%0d required %h", got, seen, cyc, e);
      end
      step();
      start_req(1'b1, 32'h0000_B004, 32'hA5A5A5A5, 4'b1111, LT_NONE);
      step();
      end_req();
      wait_done(10, seen, cyc);
      got = {load_valid, store_done, access_fault, misaligned, load_data};
      e   = exp_q.pop_front();
      tests_run++;
      if (!seen || cyc != 2 || got !== e) begin
         fails++;
         $display("FAIL b2b_second: got %h seen=%0d cyc=%0d required %h", got, seen, cyc, e);
      end
      step();
   endtask

   initial begin
      #1;
      test_reset();
      test_lw();
      test_load_format();
      test_store();
      test_misaligned();
      test_timeout();
      test_rsp_err();
      test_reset_mid();
      test_back_to_back();
      tests_run++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d leftover required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
